// File: rtl/vga_pkg.sv
// Shared VGA timing package: scan phase encoding and the default
// 640x480@60 timing constants used by the scan generator and the renderers.
package vga_pkg;

    // Phase of one scan axis. The encoding is fixed so that debug
    // probes and older consumers see the same values across builds.
    typedef logic [1:0] phase_t;

    localparam phase_t PH_ACTIVE = 2'd0;
    localparam phase_t PH_FRONT  = 2'd1;
    localparam phase_t PH_SYNC   = 2'd2;
    localparam phase_t PH_BACK   = 2'd3;

    // 640x480@60 from a 50 MHz system clock (25 MHz pixel rate).
    localparam int VGA_ACTIVE_COLS    = 640;
    localparam int VGA_ACTIVE_ROWS    = 480;
    localparam int VGA_H_FP           = 16;
    localparam int VGA_H_SYNC         = 96;
    localparam int VGA_H_BP           = 48;
    localparam int VGA_V_FP           = 10;
    localparam int VGA_V_SYNC         = 2;
    localparam int VGA_V_BP           = 33;
    localparam int VGA_CLKS_PER_PIXEL = 2;

    // Total length of one axis (visible part plus blanking).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster output bundle of the scan generator, plus the phase/counter
// debug view of both axes.
//
// Strobe semantics: pix_en acts as the "valid" of this bundle. row, col,
// active, hsync and vsync are registered and change only on the edge that
// raises pix_en; they then hold for the whole pixel period. line_start and
// frame_start are only meaningful in the cycle where pix_en is high. There
// is no ready: the raster never stalls, consumers must keep up.
interface vga_scan_gen_if
    import vga_pkg::*;
#(
    parameter int COL_W = 10,
    parameter int ROW_W = 9,
    parameter int H_W   = 10,
    parameter int V_W   = 10
) ();

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             pix_en;
    logic             line_start;
    logic             frame_start;

    // Debug view of the two axis FSMs.
    phase_t           h_phase;
    phase_t           v_phase;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             v_wrap;

    modport master (
        output row, col, active, hsync, vsync, pix_en, line_start, frame_start,
        output h_phase, v_phase, h_cnt, v_cnt, v_wrap
    );

    modport slave (
        input row, col, active, hsync, vsync, pix_en, line_start, frame_start,
        input h_phase, v_phase, h_cnt, v_cnt, v_wrap
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: a position counter over active+fp+sync+bp plus the phase
// FSM walking ACTIVE -> FRONT -> SYNC -> BACK. Both the registered and the
// next-state values are exported so the parent can register its outputs
// in the same edge as the counter moves.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output phase_t        phase,
    output phase_t        phase_nxt,
    output logic          wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    // Positions at which the phase changes (first position of each phase).
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FRONT_POS  = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_POS   = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BACK_POS   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_q, count_d;
    phase_t        phase_q, phase_d;

    // The axis is about to wrap on its next step when sitting on the last position.
    assign wrap = (count_q == LAST);

    // Next position and phase; the phase follows the position it moves to.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + CW'(1);
            case (phase_q)
                PH_ACTIVE: if (count_d == FRONT_POS) phase_d = PH_FRONT;
                PH_FRONT:  if (count_d == SYNC_POS)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_d == BACK_POS)  phase_d = PH_BACK;
                PH_BACK:   if (count_d == '0)        phase_d = PH_ACTIVE;
                default:                             phase_d = PH_BACK;
            endcase
        end
    end

    // Reset parks the axis on its last back-porch position so the first
    // step lands on position 0 in the active phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= LAST;
            phase_q <= PH_BACK;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign phase     = phase_q;
    assign phase_nxt = phase_d;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: divides clk down to the pixel rate, walks the
// horizontal and vertical timing and produces registered row/col, active,
// sync pins and the pixel/line/frame strobes.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLS     = VGA_ACTIVE_COLS,
    parameter int ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int CLKS_PER_PIXEL  = VGA_CLKS_PER_PIXEL,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_gen_if.master vga
);

    localparam int H_TOTAL = axis_total(ACTIVE_COLS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(ACTIVE_ROWS, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int COL_W   = $clog2(ACTIVE_COLS);
    localparam int ROW_W   = $clog2(ACTIVE_ROWS);
    localparam int DIV_W   = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_PIXEL - 1);
    localparam logic             SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic             SYNC_OFF = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // Pixel-rate divider: one step every CLKS_PER_PIXEL clocks. Starting
    // from 0 after reset, the first step falls on the CLKS_PER_PIXEL-th edge.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             step;

    // Divider wrap is the pixel step.
    always_comb begin
        step  = (div_q == DIV_LAST);
        div_d = step ? '0 : div_q + DIV_W'(1);
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Axis counters. The vertical axis advances once per line, on the
    // step that wraps the horizontal axis.
    // ------------------------------------------------------------------
    logic [H_W-1:0] h_cnt, h_cnt_nxt;
    logic [V_W-1:0] v_cnt, v_cnt_nxt;
    phase_t         h_phase, h_phase_nxt;
    phase_t         v_phase, v_phase_nxt;
    logic           h_wrap, v_wrap;
    logic           v_step;

    assign v_step = step & h_wrap;

    vga_axis_counter #(
        .ACTIVE (ACTIVE_COLS),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (H_W)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .count     (h_cnt),
        .count_nxt (h_cnt_nxt),
        .phase     (h_phase),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (ACTIVE_ROWS),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (V_W)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (v_step),
        .count     (v_cnt),
        .count_nxt (v_cnt_nxt),
        .phase     (v_phase),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    // ------------------------------------------------------------------
    // Registered output decode. Outputs are computed from the position the
    // counters move to, so they line up with the counters after each step.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             active_q, active_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             pix_en_q, pix_en_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Decode the next position on step edges; hold levels and drop strobes otherwise.
    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        pix_en_d      = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (step) begin
            pix_en_d      = 1'b1;
            active_d      = (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
            col_d         = active_d ? h_cnt_nxt[COL_W-1:0] : '0;
            row_d         = active_d ? v_cnt_nxt[ROW_W-1:0] : '0;
            hsync_d       = (h_phase_nxt == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            vsync_d       = (v_phase_nxt == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            line_start_d  = active_d && (h_cnt_nxt == '0);
            frame_start_d = line_start_d && (v_cnt_nxt == '0);
        end
    end

    // Output registers; reset truncates any sync pulse in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q         <= '0;
            col_q         <= '0;
            active_q      <= 1'b0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.row         = row_q;
    assign vga.col         = col_q;
    assign vga.active      = active_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.pix_en      = pix_en_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

    assign vga.h_phase     = h_phase;
    assign vga.v_phase     = v_phase;
    assign vga.h_cnt       = h_cnt;
    assign vga.v_cnt       = v_cnt;
    assign vga.v_wrap      = v_wrap;

endmodule
